// File: rtl/obi_wb_pkg.sv
// obi_wb_pkg: shared state type, default widths and select-width helper for the OBI-to-Wishbone bridge
package obi_wb_pkg;
  typedef enum logic [1:0] {IDLE, BUS, RESP} bridge_state_e;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  function automatic int sel_width(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/obi_wb_bridge.sv
// obi_wb_bridge: single-outstanding OBI request channel to Wishbone classic initiator
// with registered request fields, one-cycle response pulse, error and timeout reporting
module obi_wb_bridge
  import obi_wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               obi_req_i,
  output logic                               obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0]              obi_addr_i,
  input  logic                               obi_we_i,
  input  logic [sel_width(DATA_WIDTH)-1:0]   obi_be_i,
  input  logic [DATA_WIDTH-1:0]              obi_wdata_i,
  output logic                               obi_rvalid_o,
  output logic [DATA_WIDTH-1:0]              obi_rdata_o,
  output logic                               obi_err_o,
  output logic                               wb_cyc_o,
  output logic                               wb_stb_o,
  output logic                               wb_we_o,
  output logic [sel_width(DATA_WIDTH)-1:0]   wb_sel_o,
  output logic [ADDR_WIDTH-1:0]              wb_adr_o,
  output logic [DATA_WIDTH-1:0]              wb_dat_o,
  input  logic [DATA_WIDTH-1:0]              wb_dat_i,
  input  logic                               wb_ack_i,
  input  logic                               wb_err_i
);
  localparam int SW = sel_width(DATA_WIDTH);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  bridge_state_e         r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_we;
  logic                  r_err;
  logic [SW-1:0]         r_be;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_to;
  assign w_to         = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);
  assign obi_gnt_o    = obi_req_i && (r_state == IDLE || r_state == RESP);
  assign wb_cyc_o     = (r_state == BUS);
  assign wb_stb_o     = (r_state == BUS);
  assign wb_we_o      = r_we;
  assign wb_sel_o     = r_be;
  assign wb_adr_o     = r_addr;
  assign wb_dat_o     = r_wdata;
  assign obi_rvalid_o = (r_state == RESP);
  assign obi_err_o    = (r_state == RESP) && r_err;
  assign obi_rdata_o  = r_rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else if (obi_gnt_o) begin
      r_state <= BUS;
      r_cnt   <= '0;
      r_we    <= obi_we_i;
      r_be    <= obi_be_i;
      r_addr  <= obi_addr_i;
      r_wdata <= obi_wdata_i;
    end else if (r_state == RESP) begin
      r_state <= IDLE;
    end else if (r_state == BUS) begin
      if (wb_ack_i || wb_err_i || w_to) begin
        r_state <= RESP;
        // a timeout (no ack) reports as an error just like wb_err_i
        r_err   <= wb_err_i || !wb_ack_i;
        r_rdata <= (wb_ack_i && !wb_err_i && !r_we) ? wb_dat_i : '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule
